// File: rtl/elastic_node_if.sv
// Handshake bundle between an elastic_node and its upstream/downstream neighbours.
// The stall_cnt signal exists only when ELASTIC_NODE_STALL_CNT_EN is defined.
interface elastic_node_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_in;
    logic             up_valid_in;
    logic             up_ready_out;
    logic [WIDTH-1:0] data_out;
    logic             dn_valid_out;
    logic             dn_ready_in;
    logic [CW-1:0]    occupancy;
`ifdef ELASTIC_NODE_STALL_CNT_EN
    logic [15:0]      stall_cnt;

    modport slave (
        input  data_in, up_valid_in, dn_ready_in,
        output up_ready_out, data_out, dn_valid_out, occupancy, stall_cnt
    );
    modport master (
        output data_in, up_valid_in, dn_ready_in,
        input  up_ready_out, data_out, dn_valid_out, occupancy, stall_cnt
    );
`else
    modport slave (
        input  data_in, up_valid_in, dn_ready_in,
        output up_ready_out, data_out, dn_valid_out, occupancy
    );
    modport master (
        output data_in, up_valid_in, dn_ready_in,
        input  up_ready_out, data_out, dn_valid_out, occupancy
    );
`endif
endinterface

// File: rtl/elastic_node.sv
// Elastic pipeline node: DEPTH-entry circular buffer with valid/ready on both sides.
// Optional stall counter enabled by defining ELASTIC_NODE_STALL_CNT_EN.
module elastic_node #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    elastic_node_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
        $error("elastic_node: WIDTH out of range");
    end
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("elastic_node: DEPTH must be a power of two in 2..256");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             up_fire;
    logic             dn_fire;

    // Ready/valid come only from count, so neither side sees the other combinationally.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign up_fire = bus.up_valid_in & ~full;
    assign dn_fire = ~empty & bus.dn_ready_in;

    assign bus.up_ready_out = ~full;
    assign bus.dn_valid_out = ~empty;
    assign bus.data_out     = mem[rd_ptr];
    assign bus.occupancy    = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (up_fire) begin
                mem[wr_ptr] <= bus.data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (dn_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({up_fire, dn_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ELASTIC_NODE_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (~empty && !bus.dn_ready_in && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_elastic_node.sv
// Directed bench for elastic_node (WIDTH=16, DEPTH=4) with hand-computed expectations.
// Stall counter steps run only when ELASTIC_NODE_STALL_CNT_EN is defined.
module tb_elastic_node;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   xfers;

    elastic_node_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    elastic_node #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.data_in     = '0;
        bus.up_valid_in = 1'b0;
        bus.dn_ready_in = 1'b0;
        @(negedge clk);

        // reset then idle
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_ready", 32'(bus.up_ready_out), 32'd1);
        chk("idle_valid", 32'(bus.dn_valid_out), 32'd0);
        chk("idle_data",  32'(bus.data_out),     32'h0);
        chk("idle_occ",   32'(bus.occupancy),    32'd0);

        // fill to full with downstream stalled
        bus.up_valid_in = 1'b1;
        bus.data_in = 16'h11; tick();
        chk("fill_lat_valid", 32'(bus.dn_valid_out), 32'd1);
        chk("fill_lat_data",  32'(bus.data_out),     32'h11);
        bus.data_in = 16'h22; tick();
        bus.data_in = 16'h33; tick();
        bus.data_in = 16'h44; tick();
        chk("full_occ",   32'(bus.occupancy),    32'd4);
        chk("full_ready", 32'(bus.up_ready_out), 32'd0);
        bus.data_in = 16'h55; tick();
        tick();
        chk("full_hold_occ",  32'(bus.occupancy), 32'd4);
        chk("full_hold_head", 32'(bus.data_out),  32'h11);

        // release downstream while 0x55 is still offered; full blocks the write on this edge
        bus.dn_ready_in = 1'b1;
        chk("drain0_data", 32'(bus.data_out), 32'h11);
        tick();
        chk("drain1_occ",   32'(bus.occupancy),    32'd3);
        chk("drain1_ready", 32'(bus.up_ready_out), 32'd1);
        chk("drain1_data",  32'(bus.data_out),     32'h22);
        tick();
        bus.up_valid_in = 1'b0;
        chk("drain2_occ",  32'(bus.occupancy), 32'd3);
        chk("drain2_data", 32'(bus.data_out),  32'h33);
        tick();
        chk("drain3_data", 32'(bus.data_out), 32'h44);
        tick();
        chk("drain4_data", 32'(bus.data_out),  32'h55);
        chk("drain4_occ",  32'(bus.occupancy), 32'd1);
        tick();
        chk("drain_empty_valid", 32'(bus.dn_valid_out), 32'd0);
        chk("drain_empty_occ",   32'(bus.occupancy),    32'd0);

        // streaming: 8 payloads back-to-back, downstream always ready
        xfers = 0;
        for (int i = 0; i < 8; i++) begin
            bus.up_valid_in = 1'b1;
            bus.data_in = 16'hA0 + 16'(i);
            if (bus.dn_valid_out && bus.dn_ready_in) xfers++;
            tick();
            chk("stream_valid", 32'(bus.dn_valid_out), 32'd1);
            chk("stream_data",  32'(bus.data_out),     32'hA0 + 32'(i));
            chk("stream_occ",   32'(bus.occupancy),    32'd1);
        end
        bus.up_valid_in = 1'b0;
        if (bus.dn_valid_out && bus.dn_ready_in) xfers++;
        tick();
        chk("stream_xfers_9cyc", 32'(xfers), 32'd8);
        chk("stream_end_occ", 32'(bus.occupancy), 32'd0);

        // occupancy 2 with simultaneous push/pop across several pointer wraps
        bus.dn_ready_in = 1'b0;
        bus.up_valid_in = 1'b1;
        bus.data_in = 16'h100; tick();
        bus.data_in = 16'h101; tick();
        chk("pp_start_occ", 32'(bus.occupancy), 32'd2);
        bus.dn_ready_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus.data_in = 16'h102 + 16'(k);
            chk("pp_head", 32'(bus.data_out),  32'h100 + 32'(k));
            tick();
            chk("pp_occ",  32'(bus.occupancy), 32'd2);
        end
        bus.up_valid_in = 1'b0;
        chk("pp_tail0", 32'(bus.data_out), 32'h10C);
        tick();
        chk("pp_tail1", 32'(bus.data_out), 32'h10D);
        tick();
        chk("pp_drained", 32'(bus.occupancy), 32'd0);

        // reset mid-operation at occupancy 3, with a push offered on the reset edge
        bus.dn_ready_in = 1'b0;
        bus.up_valid_in = 1'b1;
        bus.data_in = 16'h0001; tick();
        bus.data_in = 16'h0002; tick();
        bus.data_in = 16'h0003; tick();
        chk("pre_rst_occ", 32'(bus.occupancy), 32'd3);
        rst_n = 1'b0;
        bus.data_in = 16'h1234;
        tick();
        chk("rst_occ",   32'(bus.occupancy),    32'd0);
        chk("rst_valid", 32'(bus.dn_valid_out), 32'd0);
        chk("rst_data",  32'(bus.data_out),     32'h0);
        chk("rst_ready", 32'(bus.up_ready_out), 32'd1);
        rst_n = 1'b1;
        bus.data_in = 16'hBEEF;
        tick();
        bus.up_valid_in = 1'b0;
        chk("post_rst_data", 32'(bus.data_out),  32'hBEEF);
        chk("post_rst_occ",  32'(bus.occupancy), 32'd1);
        bus.dn_ready_in = 1'b1;
        tick();
        chk("post_rst_empty", 32'(bus.occupancy), 32'd0);

`ifdef ELASTIC_NODE_STALL_CNT_EN
        rst_n = 1'b0;
        bus.dn_ready_in = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("stall_rst", 32'(bus.stall_cnt), 32'd0);
        bus.up_valid_in = 1'b1;
        bus.data_in = 16'h7777;
        tick();
        bus.up_valid_in = 1'b0;
        chk("stall_start", 32'(bus.stall_cnt), 32'd0);
        repeat (7) tick();
        chk("stall_7", 32'(bus.stall_cnt), 32'd7);
        repeat (70000) tick();
        chk("stall_sat", 32'(bus.stall_cnt), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/elastic_node.md
ELASTIC_NODE -- requirements
Module: elastic_node

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, legal range 1..1024.
REQ-002 Parameter DEPTH, default 4: buffer entries, power of two, legal range 2..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 data_in  input  WIDTH  payload from upstream node.
REQ-006 up_valid_in  input  1  upstream payload valid.
REQ-007 up_ready_out  output  1  this node can accept a payload.
REQ-008 data_out  output  WIDTH  payload to downstream node.
REQ-009 dn_valid_out  output  1  data_out valid.
REQ-010 dn_ready_in  input  1  downstream can accept.
REQ-011 occupancy  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.

Function
REQ-012 up_fire = up_valid_in & up_ready_out; dn_fire = dn_valid_out & dn_ready_in; a transfer happens only on the rising edge where the respective fire is 1.
REQ-013 Storage is a DEPTH-entry circular buffer with wr_ptr, rd_ptr and a count register; pointers wrap from DEPTH-1 to 0.
REQ-014 up_ready_out = (count != DEPTH), driven from registered state only; there is no combinational path from dn_ready_in to up_ready_out.
REQ-015 dn_valid_out = (count != 0), driven from registered state only; there is no combinational path from up_valid_in to dn_valid_out or data_in to data_out.
REQ-016 data_out = entry at rd_ptr; value when dn_valid_out is 0 is the last stored head entry (0 after reset).
REQ-017 Minimum latency: payload accepted on edge N is presented with dn_valid_out=1 in the cycle after edge N.
REQ-018 Ordering is strict FIFO; no payload is dropped, duplicated or reordered.
REQ-019 up_fire only: write data_in at wr_ptr, wr_ptr+1, count+1.
REQ-020 dn_fire only: rd_ptr+1, count-1.
REQ-021 up_fire and dn_fire on the same edge: both pointers advance, count unchanged; legal at any count 1..DEPTH-1.
REQ-022 Full (count=DEPTH): up_ready_out=0, no write regardless of up_valid_in, even if dn_ready_in=1 that cycle; ready returns the cycle after the pop.
REQ-023 Empty (count=0): dn_valid_out=0, no pop regardless of dn_ready_in; a simultaneous push lands in storage only (no bypass).
REQ-024 With dn_ready_in held 1 and up_valid_in held 1, sustained throughput is one payload per cycle after the first.
REQ-025 occupancy = count.

Reset
REQ-026 When rst_n=0 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, all storage entries=0.
REQ-027 Reset values: up_ready_out=1, dn_valid_out=0, data_out=0, occupancy=0, stall_cnt=0 (if present), effective from the edge where rst_n is sampled low.
REQ-028 Reset mid-operation discards all stored payloads; no fire is honoured on an edge where rst_n=0.

Configuration
REQ-029 Macro ELASTIC_NODE_STALL_CNT_EN defined: adds output stall_cnt, 16 bits, incremented on each edge with dn_valid_out=1 and dn_ready_in=0, saturating at 16'hFFFF, cleared only by reset.
REQ-030 Macro ELASTIC_NODE_STALL_CNT_EN undefined: port stall_cnt and its logic are absent; all other behaviour identical.

Verification
REQ-031 Reset, then idle 5 cycles -> up_ready_out=1, dn_valid_out=0, data_out=0, occupancy=0.
REQ-032 DEPTH=4, dn_ready_in=0, push 0x11,0x22,0x33,0x44,0x55 -> first four accepted, occupancy=4, up_ready_out=0, 0x55 held upstream; raise dn_ready_in -> outputs 0x11..0x55 in order.
REQ-033 dn_ready_in=1, push 0xA0..0xA7 back-to-back -> each appears one cycle after acceptance, occupancy stays 1, 8 transfers in 9 cycles.
REQ-034 Occupancy 2, push and pop on same edge -> occupancy stays 2, order preserved; repeat across pointer wrap (10+ transfers) with no corruption.
REQ-035 Occupancy 3, assert rst_n=0 one cycle -> next cycle occupancy=0, dn_valid_out=0; subsequent push 0xBEEF emerges as first output.
REQ-036 With ELASTIC_NODE_STALL_CNT_EN: hold dn_valid_out=1, dn_ready_in=0 for 7 cycles -> stall_cnt=7; 70000 cycles -> stall_cnt=0xFFFF.
